uart_tx_fifo: RTL and testbench

Parametrised next-generation UART transmit engine with a built-in transmit FIFO.
- CPU-side writes queue bytes without waiting per character.
- Frame format is runtime-programmable: 7/8 data bits, optional odd/even parity, 1 or 2 stop bits.
- Adds break generation, overflow detection and a FIFO level output.
- Sits between the bus/port decoder (write strobe + out_port byte) and the TX pin, beside the baud-rate register that supplies k.

---
 rtl/uart_pkg.sv | 48 ++++
 rtl/sync_fifo.sv | 54 +++++
 rtl/uart_tx_fifo.sv | 140 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and frame-building helpers for the queued UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        BREAK
    } state_t;

    localparam int MAX_FRAME_BITS = 12;

    // Parity covers only the bits actually sent; odd sense inverts the even result.
    function automatic logic calc_parity(input logic [7:0] data,
                                         input logic       eight,
                                         input logic       ohel);
        return (^data[6:0]) ^ (eight & data[7]) ^ ohel;
    endfunction

    function automatic logic [3:0] frame_len(input logic eight,
                                             input logic pen,
                                             input logic two_stop);
        return 4'd9 + {3'b000, eight} + {3'b000, pen} + {3'b000, two_stop};
    endfunction

    // Unused upper positions stay 1 so the stop bits fall out naturally.
    function automatic logic [MAX_FRAME_BITS-1:0] build_frame(input logic [7:0] data,
                                                              input logic       eight,
                                                              input logic       pen,
                                                              input logic       ohel,
                                                              input logic       two_stop);
        logic [MAX_FRAME_BITS-1:0] f;
        logic                      p;
        f      = '1;
        p      = calc_parity(data, eight, ohel);
        f[0]   = 1'b0;
        f[7:1] = data[6:0];
        if (eight) begin
            f[8] = data[7];
            if (pen) f[9] = p;
        end else if (pen) begin
            f[8] = p;
        end
        if (two_stop) f[MAX_FRAME_BITS-1] = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; a push into a full FIFO is accepted when a pop happens on the same edge.
module sync_fifo
    import uart_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Power-of-two depth lets the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit engine fed by a byte FIFO, with runtime frame format, break generation and overflow flag.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int FIFO_DEPTH = 16,
    parameter  int BAUD_W     = 19,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic [7:0]        out_port,
    input  logic              eight,
    input  logic              pen,
    input  logic              ohel,
    input  logic              two_stop,
    input  logic              brk,
    input  logic              ovf_clr,
    input  logic [BAUD_W-1:0] k,
    output logic              TX,
    output logic              TXRDY,
    output logic              busy,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              ovf
);

    state_t                    state;
    logic                      tx_q;
    logic                      ovf_q;
    logic [MAX_FRAME_BITS-1:0] shreg;
    logic [MAX_FRAME_BITS-1:0] next_frame;
    logic [BAUD_W-1:0]         baud_cnt;
    logic [BAUD_W-1:0]         k_lat;
    logic [3:0]                bit_idx;
    logic [3:0]                nbits;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      pop;
    logic [7:0]                head;

    assign pop = (state == LOAD);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (write),
        .pop   (pop),
        .din   (out_port),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign next_frame = build_frame(head, eight, pen, ohel, two_stop);

    assign TX    = tx_q;
    assign TXRDY = ~fifo_full;
    assign ovf   = ovf_q;
    assign busy  = (state != IDLE) | (fifo_count != '0);

    // A write lost to a full FIFO wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (write && fifo_full && !pop) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    // LOAD drives the start bit straight away, so SHIFT counts out the remaining bit times.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tx_q     <= 1'b1;
            shreg    <= '1;
            baud_cnt <= '0;
            k_lat    <= '0;
            bit_idx  <= '0;
            nbits    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx_q     <= 1'b1;
                    baud_cnt <= '0;
                    if (brk) begin
                        state <= BREAK;
                    end else if (!fifo_empty) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    tx_q     <= next_frame[0];
                    shreg    <= {1'b1, next_frame[MAX_FRAME_BITS-1:1]};
                    k_lat    <= k;
                    nbits    <= frame_len(eight, pen, two_stop);
                    bit_idx  <= '0;
                    baud_cnt <= '0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (baud_cnt == k_lat) begin
                        baud_cnt <= '0;
                        if (bit_idx == nbits - 4'd1) begin
                            tx_q  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            tx_q    <= shreg[0];
                            shreg   <= {1'b1, shreg[MAX_FRAME_BITS-1:1]};
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (brk) begin
                        tx_q     <= 1'b0;
                        baud_cnt <= '0;
                    end else begin
                        tx_q <= 1'b1;
                        if (baud_cnt == k) begin
                            baud_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a model frame is queued per accepted write and a line monitor checks every TX clock.
module tb_uart_tx_fifo;

    localparam int FIFO_DEPTH = 16;
    localparam int BAUD_W     = 19;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    typedef struct {
        logic [11:0] bits;
        int          nbits;
        int          k;
    } frame_t;

    logic              clk      = 1'b0;
    logic              rst      = 1'b0;
    logic              write    = 1'b0;
    logic [7:0]        out_port = 8'h00;
    logic              eight    = 1'b1;
    logic              pen      = 1'b0;
    logic              ohel     = 1'b0;
    logic              two_stop = 1'b0;
    logic              brk      = 1'b0;
    logic              ovf_clr  = 1'b0;
    logic [BAUD_W-1:0] k        = '0;
    logic              tx;
    logic              txrdy;
    logic              busy;
    logic              ovf;
    logic [CNT_W-1:0]  fifo_count;

    frame_t sb[$];
    int     checks         = 0;
    int     failures       = 0;
    int     frames_done    = 0;
    int     cyc            = 0;
    int     last_end_cyc   = 0;
    int     last_start_cyc = 0;
    logic   mon_en         = 1'b1;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .BAUD_W     (BAUD_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .write      (write),
        .out_port   (out_port),
        .eight      (eight),
        .pen        (pen),
        .ohel       (ohel),
        .two_stop   (two_stop),
        .brk        (brk),
        .ovf_clr    (ovf_clr),
        .k          (k),
        .TX         (tx),
        .TXRDY      (txrdy),
        .busy       (busy),
        .fifo_count (fifo_count),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic frame_t model_frame(input logic [7:0] d, input logic e8, input logic p_en,
                                           input logic odd, input logic two, input int kk);
        frame_t f;
        int     n    = 0;
        int     ones = 0;
        int     nd   = e8 ? 8 : 7;
        f.bits    = '1;
        f.bits[n] = 1'b0;
        n++;
        for (int i = 0; i < nd; i++) begin
            f.bits[n] = d[i];
            ones += int'(d[i]);
            n++;
        end
        if (p_en) begin
            f.bits[n] = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
            n++;
        end
        f.bits[n] = 1'b1;
        n++;
        if (two) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.nbits = n;
        f.k     = kk;
        return f;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called on a falling clock edge; leaves write low one cycle later so calls chain back-to-back.
    task automatic applyStimulus(input logic [7:0] data, input logic expect_accept);
        write    = 1'b1;
        out_port = data;
        if (expect_accept) sb.push_back(model_frame(data, eight, pen, ohel, two_stop, int'(k)));
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic waitFrames(input int target, input int budget, input string tag);
        int n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, frames_done, target);
    endtask

    task automatic waitStart(input int budget, input string tag);
        int n = 0;
        while (tx !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, tx, 0);
    endtask

    initial begin : monitor
        logic   prev;
        logic   aborted;
        frame_t e;
        int     fnum;
        prev = 1'b1;
        fnum = 0;
        forever begin
            @(negedge clk);
            if (rst && mon_en && prev && !tx) begin
                last_start_cyc = cyc;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_start", tx, 1);
                end else begin
                    e       = sb.pop_front();
                    aborted = 1'b0;
                    for (int b = 0; b < e.nbits && !aborted; b++) begin
                        for (int c = 0; c <= e.k && !aborted; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (!rst) aborted = 1'b1;
                            else checkOutput($sformatf("frame%0d_bit%0d", fnum, b), tx, e.bits[b]);
                        end
                    end
                    fnum++;
                    if (!aborted) begin
                        frames_done++;
                        last_end_cyc = cyc;
                    end
                end
            end
            prev = tx;
        end
    end

    initial begin
        int end1;
        int start2;

        repeat (3) @(negedge clk);
        checkOutput("reset_tx", tx, 1);
        checkOutput("reset_txrdy", txrdy, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_count", fifo_count, 0);
        checkOutput("reset_ovf", ovf, 0);
        rst = 1'b1;
        @(negedge clk);

        // 8 data bits, even parity, one stop, 4-clock bits
        k = 3; eight = 1; pen = 1; ohel = 0; two_stop = 0;
        applyStimulus(8'hA5, 1'b1);
        checkOutput("t1_count_after_write", fifo_count, 1);
        checkOutput("t1_busy", busy, 1);
        checkOutput("t1_tx_at_n", tx, 1);
        @(negedge clk);
        checkOutput("t1_tx_at_n1", tx, 1);
        @(negedge clk);
        checkOutput("t1_start_at_n2", tx, 0);
        waitFrames(1, 200, "t1_frame_done");

        // 7 data bits, odd parity, two stops, 1-clock bits
        eight = 0; pen = 1; ohel = 1; two_stop = 1; k = 0;
        @(negedge clk);
        applyStimulus(8'h41, 1'b1);
        waitFrames(2, 100, "t2_frame_done");
        if (cyc == last_end_cyc) @(negedge clk);
        checkOutput("t2_busy_after_stop", busy, 0);
        checkOutput("t2_tx_idle", tx, 1);

        eight = 1; pen = 0; ohel = 0; two_stop = 0; k = 100;
        @(negedge clk);
        for (int i = 0; i < 17; i++) applyStimulus(8'(i * 13 + 7), 1'b1);
        checkOutput("t3_count_full", fifo_count, 16);
        checkOutput("t3_txrdy_full", txrdy, 0);
        checkOutput("t3_ovf_before", ovf, 0);
        applyStimulus(8'hEE, 1'b0);
        checkOutput("t3_ovf_set", ovf, 1);
        checkOutput("t3_count_after_ovf", fifo_count, 16);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checkOutput("t3_ovf_cleared", ovf, 0);
        waitFrames(19, 17 * 12 * 101 + 400, "t3_all_frames");
        checkOutput("t3_txrdy_drained", txrdy, 1);
        checkOutput("t3_count_drained", fifo_count, 0);

        k = 1;
        @(negedge clk);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        checkOutput("t4_count_2", fifo_count, 2);
        @(negedge clk);
        checkOutput("t4_count_1", fifo_count, 1);
        checkOutput("t4_first_start", tx, 0);
        waitFrames(20, 100, "t4_first_done");
        end1 = last_end_cyc;
        waitFrames(21, 100, "t4_second_done");
        start2 = last_start_cyc;
        checkOutput("t4_gap_bounded", ((start2 - end1) <= 3) ? 1 : 0, 1);
        checkOutput("t4_count_0", fifo_count, 0);

        // Break requested mid-frame; a byte queued behind it must wait for the break to end
        k = 3;
        @(negedge clk);
        applyStimulus(8'h5A, 1'b1);
        waitStart(20, "t5_start_seen");
        brk    = 1'b1;
        mon_en = 1'b0;
        applyStimulus(8'hC3, 1'b1);
        waitFrames(22, 200, "t5_frame_before_break");
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            checkOutput("t5_break_low", tx, 0);
            @(negedge clk);
        end
        checkOutput("t5_busy_in_break", busy, 1);
        brk = 1'b0;
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            checkOutput("t5_release_high", tx, 1);
        end
        mon_en = 1'b1;
        waitFrames(23, 200, "t5_queued_after_break");

        applyStimulus(8'h96, 1'b1);
        applyStimulus(8'h3C, 1'b1);
        waitStart(20, "t6_start_seen");
        repeat (17) @(negedge clk);
        checkOutput("t6_count_before", fifo_count, 1);
        checkOutput("t6_tx_data3", tx, 0);
        #2;
        rst = 1'b0;
        sb.delete();
        #1;
        checkOutput("t6_reset_tx", tx, 1);
        checkOutput("t6_reset_count", fifo_count, 0);
        checkOutput("t6_reset_txrdy", txrdy, 1);
        checkOutput("t6_reset_ovf", ovf, 0);
        checkOutput("t6_reset_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("t6_idle_tx", tx, 1);
        checkOutput("t6_idle_busy", busy, 0);
        checkOutput("t6_idle_count", fifo_count, 0);
        checkOutput("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
